// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Latency: n/a (types, decoder codes and helpers only).
// Backpressure: n/a.
package muldiv_unit_pkg;

    // Decoder ALUCtrl codes this unit answers to (M codes occupy 5'b10xxx)
    localparam logic [4:0] ALUCTRL_ADD    = 5'b00000;
    localparam logic [4:0] ALUCTRL_SUB    = 5'b00001;
    localparam logic [4:0] ALUCTRL_MUL    = 5'b10000;
    localparam logic [4:0] ALUCTRL_MULH   = 5'b10001;
    localparam logic [4:0] ALUCTRL_MULHSU = 5'b10010;
    localparam logic [4:0] ALUCTRL_MULHU  = 5'b10011;
    localparam logic [4:0] ALUCTRL_DIV    = 5'b10100;
    localparam logic [4:0] ALUCTRL_DIVU   = 5'b10101;
    localparam logic [4:0] ALUCTRL_REM    = 5'b10110;
    localparam logic [4:0] ALUCTRL_REMU   = 5'b10111;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // True for any of the eight RV32M codes
    function automatic logic is_muldiv(input logic [4:0] c);
        return (c[4:3] == 2'b10);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 step on unsigned magnitudes: shift-add multiply or restoring divide.
// Latency: combinational; the caller registers the accumulator each cycle.
// Backpressure: none; the caller decides when to step.
module muldiv_iter_core #(
    parameter int BITS = 32
) (
    input  logic [2*BITS-1:0] i_acc,
    input  logic [BITS-1:0]   i_opnd,
    input  logic              i_div,
    output logic [2*BITS-1:0] o_acc
);

    logic [BITS:0]   w_sum;
    logic [BITS:0]   w_rem_sh;
    logic [BITS+1:0] w_diff;

    // Multiply: acc = {partial product high, multiplier low}; add multiplicand when the
    // current multiplier bit is set, then shift right. Divide: acc = {remainder, dividend};
    // shift left, trial-subtract divisor, keep the difference and set the quotient bit
    // when it did not borrow.
    always_comb begin
        w_sum    = {1'b0, i_acc[2*BITS-1:BITS]} + (i_acc[0] ? {1'b0, i_opnd} : {(BITS+1){1'b0}});
        w_rem_sh = i_acc[2*BITS-1:BITS-1];
        w_diff   = {1'b0, w_rem_sh} - {2'b00, i_opnd};
        o_acc    = {w_sum, i_acc[BITS-1:1]};
        if (i_div) begin
            if (w_diff[BITS+1]) begin
                o_acc = {w_rem_sh[BITS-1:0], i_acc[BITS-2:0], 1'b0};
            end else begin
                o_acc = {w_diff[BITS-1:0], i_acc[BITS-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Latency: BITS+1 cycles from accept to out_valid; div-by-zero/overflow ready right after accept.
// Backpressure: in_ready only in IDLE; result held with out_valid until out_ready.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_ctrl,
    input  logic [BITS-1:0] op_a,
    input  logic [BITS-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] result
);

    localparam int              CW      = $clog2(BITS + 1);
    localparam logic [CW-1:0]   LAST    = CW'(BITS - 1);
    localparam logic [BITS-1:0] MIN_INT = {1'b1, {(BITS-1){1'b0}}};

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [BITS-1:0]   r_result;
    logic [CW-1:0]     r_cnt;
    logic [2*BITS-1:0] r_acc;
    logic [BITS-1:0]   r_opnd;
    logic              r_is_div;
    logic              r_is_rem;
    logic              r_mul_hi;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_accept;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_is_div;
    logic              w_is_rem;
    logic              w_mul_hi;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [BITS-1:0]   w_abs_a;
    logic [BITS-1:0]   w_abs_b;
    logic              w_div0;
    logic              w_ovf;
    logic [BITS-1:0]   w_fast_res;
    logic [2*BITS-1:0] w_acc_next;
    logic [2*BITS-1:0] w_prod;
    logic [BITS-1:0]   w_quot;
    logic [BITS-1:0]   w_rem;
    logic [BITS-1:0]   w_fix_res;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

    // Decode the presented op: signedness, operand magnitudes and the two fast-path cases
    always_comb begin
        w_accept   = in_valid && r_in_ready && is_muldiv(alu_ctrl);
        w_a_signed = (alu_ctrl == ALUCTRL_MUL) || (alu_ctrl == ALUCTRL_MULH) ||
                     (alu_ctrl == ALUCTRL_MULHSU) || (alu_ctrl == ALUCTRL_DIV) ||
                     (alu_ctrl == ALUCTRL_REM);
        w_b_signed = (alu_ctrl == ALUCTRL_MUL) || (alu_ctrl == ALUCTRL_MULH) ||
                     (alu_ctrl == ALUCTRL_DIV) || (alu_ctrl == ALUCTRL_REM);
        w_is_div   = (alu_ctrl == ALUCTRL_DIV) || (alu_ctrl == ALUCTRL_DIVU) ||
                     (alu_ctrl == ALUCTRL_REM) || (alu_ctrl == ALUCTRL_REMU);
        w_is_rem   = (alu_ctrl == ALUCTRL_REM) || (alu_ctrl == ALUCTRL_REMU);
        w_mul_hi   = (alu_ctrl == ALUCTRL_MULH) || (alu_ctrl == ALUCTRL_MULHSU) ||
                     (alu_ctrl == ALUCTRL_MULHU);
        w_a_neg    = w_a_signed && op_a[BITS-1];
        w_b_neg    = w_b_signed && op_b[BITS-1];
        w_abs_a    = w_a_neg ? (~op_a + 1'b1) : op_a;
        w_abs_b    = w_b_neg ? (~op_b + 1'b1) : op_b;
        w_div0     = w_is_div && (op_b == '0);
        w_ovf      = w_is_div && w_b_signed && (op_a == MIN_INT) && (op_b == '1);
        if (w_div0) begin
            w_fast_res = w_is_rem ? op_a : '1;
        end else begin
            w_fast_res = w_is_rem ? '0 : op_a;
        end
    end

    // Final sign correction and result selection from the finished accumulator
    always_comb begin
        w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
        w_quot = r_neg_q ? (~r_acc[BITS-1:0] + 1'b1) : r_acc[BITS-1:0];
        w_rem  = r_neg_r ? (~r_acc[2*BITS-1:BITS] + 1'b1) : r_acc[2*BITS-1:BITS];
        if (r_is_div) begin
            w_fix_res = r_is_rem ? w_rem : w_quot;
        end else begin
            w_fix_res = r_mul_hi ? w_prod[2*BITS-1:BITS] : w_prod[BITS-1:0];
        end
    end

    muldiv_iter_core #(
        .BITS   (BITS)
    ) u_core (
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .i_div  (r_is_div),
        .o_acc  (w_acc_next)
    );

    // Sequencer: accept, iterate BITS steps, fix signs, hold the result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_is_div    <= 1'b0;
            r_is_rem    <= 1'b0;
            r_mul_hi    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
        end else if (flush) begin
            // Kill whatever is in flight; a held result is dropped but left in r_result
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_is_div   <= w_is_div;
                        r_is_rem   <= w_is_rem;
                        r_mul_hi   <= w_mul_hi;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_cnt      <= '0;
                        if (w_div0 || w_ovf) begin
                            r_result    <= w_fast_res;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (w_is_div) begin
                            r_acc   <= {{BITS{1'b0}}, w_abs_a};
                            r_opnd  <= w_abs_b;
                            r_state <= S_CALC;
                        end else begin
                            r_acc   <= {{BITS{1'b0}}, w_abs_b};
                            r_opnd  <= w_abs_a;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    r_result    <= w_fix_res;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (BITS=32): directed vectors, random ops vs an arithmetic model,
// handshake hold/back-to-back, flush, mid-op reset and non-M codes.
// Inputs driven away from the rising edge; outputs sampled on the falling edge or 1ns after the rising edge.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.BITS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Architectural RV32M result computed with wide arithmetic
    function automatic logic [31:0] ref_model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub;
        logic [63:0]        p;
        int                 ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        case (c)
            ALUCTRL_MUL:    begin p = ua * ub; return p[31:0];  end
            ALUCTRL_MULH:   begin p = sa * sb; return p[63:32]; end
            ALUCTRL_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALUCTRL_MULHU:  begin p = ua * ub; return p[63:32]; end
            ALUCTRL_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            ALUCTRL_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            ALUCTRL_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            ALUCTRL_REMU: begin
                if (b == 0) return a;
                return a % b;
            end
            default: return 32'h0;
        endcase
    endfunction

    // Edges from accept to out_valid: 0 for the divide special cases, 33 otherwise
    function automatic int ref_latency(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic is_div, is_sdiv;
        is_div  = (c == ALUCTRL_DIV) || (c == ALUCTRL_DIVU) || (c == ALUCTRL_REM) || (c == ALUCTRL_REMU);
        is_sdiv = (c == ALUCTRL_DIV) || (c == ALUCTRL_REM);
        if (is_div && b == 0) return 0;
        if (is_sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Present an op at the falling edge; return 1ns after the accepting edge with junk on the operands
    task automatic start_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctrl = ALUCTRL_ADD;
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    // Count edges after the accept until out_valid, bounded; also count cycles where in_ready was seen high
    task automatic wait_done(output int n, output int rdy_err);
        n       = 0;
        rdy_err = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            if (in_ready) rdy_err++;
            @(negedge clk);
            n++;
        end
        if (in_ready) rdy_err++;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = ALUCTRL_ADD; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [4:0]  vc [12];
        logic [31:0] va [12];
        logic [31:0] vb [12];
        logic [31:0] ve [12];
        int          vl [12];
        int n, re;
        vc[0]  = ALUCTRL_MUL;    va[0]  = 32'h7;         vb[0]  = 32'hFFFF_FFFD; ve[0]  = 32'hFFFF_FFEB; vl[0]  = 33;
        vc[1]  = ALUCTRL_MULH;   va[1]  = 32'h8000_0000; vb[1]  = 32'h8000_0000; ve[1]  = 32'h4000_0000; vl[1]  = 33;
        vc[2]  = ALUCTRL_MULHU;  va[2]  = 32'hFFFF_FFFF; vb[2]  = 32'hFFFF_FFFF; ve[2]  = 32'hFFFF_FFFE; vl[2]  = 33;
        vc[3]  = ALUCTRL_MULHSU; va[3]  = 32'hFFFF_FFFF; vb[3]  = 32'hFFFF_FFFF; ve[3]  = 32'hFFFF_FFFF; vl[3]  = 33;
        vc[4]  = ALUCTRL_DIV;    va[4]  = 32'hFFFF_FFF9; vb[4]  = 32'h2;         ve[4]  = 32'hFFFF_FFFD; vl[4]  = 33;
        vc[5]  = ALUCTRL_REM;    va[5]  = 32'hFFFF_FFF9; vb[5]  = 32'h2;         ve[5]  = 32'hFFFF_FFFF; vl[5]  = 33;
        vc[6]  = ALUCTRL_DIVU;   va[6]  = 32'hFFFF_FFF9; vb[6]  = 32'h2;         ve[6]  = 32'h7FFF_FFFC; vl[6]  = 33;
        vc[7]  = ALUCTRL_REMU;   va[7]  = 32'hFFFF_FFF9; vb[7]  = 32'h2;         ve[7]  = 32'h1;         vl[7]  = 33;
        vc[8]  = ALUCTRL_DIV;    va[8]  = 32'h5;         vb[8]  = 32'h0;         ve[8]  = 32'hFFFF_FFFF; vl[8]  = 0;
        vc[9]  = ALUCTRL_REMU;   va[9]  = 32'h5;         vb[9]  = 32'h0;         ve[9]  = 32'h5;         vl[9]  = 0;
        vc[10] = ALUCTRL_DIV;    va[10] = 32'h8000_0000; vb[10] = 32'hFFFF_FFFF; ve[10] = 32'h8000_0000; vl[10] = 0;
        vc[11] = ALUCTRL_REM;    va[11] = 32'h8000_0000; vb[11] = 32'hFFFF_FFFF; ve[11] = 32'h0;         vl[11] = 0;
        for (int i = 0; i < 12; i++) begin
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_ready_before: got %b want 1", i, in_ready); end
            start_op(vc[i], va[i], vb[i]);
            wait_done(n, re);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_timeout: out_valid %b want 1", i, out_valid); end
            total++; if (result !== ve[i]) begin bad++; $display("FAIL dir%0d_result: got %h want %h", i, result, ve[i]); end
            total++; if (n !== vl[i]) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, n, vl[i]); end
            total++; if (re !== 0) begin bad++; $display("FAIL dir%0d_in_ready_busy: got %0d high cycles want 0", i, re); end
            handoff();
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++; $display("FAIL dir%0d_after_handoff: out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0]  c;
        logic [31:0] a, b, e;
        int n, re, el;
        for (int i = 0; i < 60; i++) begin
            c  = ALUCTRL_MUL + 5'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            e  = ref_model(c, a, b);
            el = ref_latency(c, a, b);
            start_op(c, a, b);
            wait_done(n, re);
            total++; if (result !== e) begin bad++; $display("FAIL rnd%0d_result op=%h a=%h b=%h: got %h want %h", i, c, a, b, result, e); end
            total++; if (n !== el) begin bad++; $display("FAIL rnd%0d_latency op=%h: got %0d want %0d", i, c, n, el); end
            total++; if (re !== 0) begin bad++; $display("FAIL rnd%0d_in_ready_busy: got %0d want 0", i, re); end
            handoff();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, held, e;
        int n, re;
        a = $urandom; b = $urandom;
        start_op(ALUCTRL_MULHU, a, b);
        wait_done(n, re);
        held = result;
        e    = ref_model(ALUCTRL_MULHU, a, b);
        total++; if (held !== e) begin bad++; $display("FAIL hold_result: got %h want %h", held, e); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || result !== held || in_ready !== 1'b0) begin
                bad++; $display("FAIL hold_cycle%0d: out_valid=%b result=%h in_ready=%b want 1/%h/0", i, out_valid, result, in_ready, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        a = $urandom; b = 32'($urandom_range(1, 1000));
        in_valid = 1'b1; alu_ctrl = ALUCTRL_DIVU; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept: in_ready=%b want 0", in_ready); end
        wait_done(n, re);
        total++; if (result !== a / b) begin bad++; $display("FAIL b2b_result: got %h want %h", result, a / b); end
        total++; if (n !== 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33", n); end
        handoff();
    endtask

    task automatic test_flush();
        int seen, n, re;
        start_op(ALUCTRL_MUL, $urandom, $urandom);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_calc: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        seen = 0;
        repeat (40) begin @(negedge clk); if (out_valid) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_calc_no_result: got %0d valid cycles want 0", seen); end
        // flush beats a simultaneous request
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; alu_ctrl = ALUCTRL_MUL; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_vs_accept: in_ready=%b want 1", in_ready); end
        seen = 0;
        repeat (40) begin @(negedge clk); if (out_valid) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_vs_accept_no_result: got %0d valid cycles want 0", seen); end
        // flush while a result waits
        start_op(ALUCTRL_REMU, 32'd9, 32'd4);
        wait_done(n, re);
        total++; if (result !== 32'd1) begin bad++; $display("FAIL flush_done_pre: got %h want 1", result); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_done: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_rst_mid();
        int seen, n, re;
        start_op(ALUCTRL_MUL, 32'd3, 32'd5);
        wait_done(n, re);
        handoff();
        total++; if (result !== 32'd15) begin bad++; $display("FAIL rst_pre_result: got %h want f", result); end
        start_op(ALUCTRL_DIV, $urandom, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
            bad++; $display("FAIL rst_mid: in_ready=%b out_valid=%b result=%h want 1/0/0", in_ready, out_valid, result);
        end
        seen = 0;
        repeat (40) begin @(negedge clk); if (out_valid) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_mid_no_result: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_non_m();
        int busy;
        busy = 0;
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = ALUCTRL_ADD; op_a = $urandom; op_b = $urandom;
        repeat (4) begin
            @(negedge clk);
            if (in_ready !== 1'b1 || out_valid !== 1'b0) busy++;
        end
        in_valid = 1'b0;
        total++; if (busy !== 0) begin bad++; $display("FAIL non_m_ignored: got %0d busy cycles want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        test_non_m();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
